// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver and transmitter.
//   rx_state_t  : receiver FSM states
//   IDLE_LEVEL  : line level while idle and for the stop bit
//   START_LEVEL : line level of the start bit
//   majority3   : 2-of-3 vote used by the optional majority sampler
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received word and status strobes out.
//   rx_in         : serial line, idle high, asynchronous to the receiver clock
//   data_out      : last good word
//   valid_out     : 1-cycle strobe, data_out updated
//   frame_err_out : 1-cycle strobe, stop bit sampled low
//   busy_out      : receiver not idle
// slave  : the receiver side
// master : the line driver / consumer side
interface uart_rx_if #(
  parameter int DATA_SIZE = 8
);

  logic                 rx_in;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 frame_err_out;
  logic                 busy_out;

  modport slave (
    input  rx_in,
    output data_out,
    output valid_out,
    output frame_err_out,
    output busy_out
  );

  modport master (
    output rx_in,
    input  data_out,
    input  valid_out,
    input  frame_err_out,
    input  busy_out
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk_in : destination clock
//   rst_in : asynchronous active-high reset, both flops load RESET_VAL
//   d_in   : asynchronous input
//   q_out  : synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out
);

  logic meta;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta  <= RESET_VAL;
      q_out <= RESET_VAL;
    end else begin
      meta  <= d_in;
      q_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style asynchronous serial receiver, LSB first, idle-high line.
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   rx_if  : uart_rx_if.slave (rx_in, data_out, valid_out, frame_err_out, busy_out)
// Parameters: CLK_BAUD_RATIO (clocks per bit, >= 4), DATA_SIZE (data bits).
// Option: define UART_RX_MAJORITY_EN to vote each bit over 3 cycles around the
//   sample point; the decision (and every strobe) then lands one cycle later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int DATA_SIZE      = 8
) (
  input  logic      clk_in,
  input  logic      rst_in,
  uart_rx_if.slave  rx_if
);

  localparam int HALF   = CLK_BAUD_RATIO / 2;
  localparam int BAUD_W = $clog2(CLK_BAUD_RATIO);
  localparam int BIT_W  = $clog2(DATA_SIZE + 2);

  // The counter reads 0 one cycle after the start edge is seen, so the nominal
  // sample point is at HALF-1; the majority vote needs one more cycle.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [BAUD_W-1:0] DECIDE_AT = BAUD_W'(HALF);
`else
  localparam logic [BAUD_W-1:0] DECIDE_AT = BAUD_W'(HALF - 1);
`endif
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_BAUD_RATIO - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  rx_state_t            state, state_nxt;
  logic                 rx_s;
  logic                 sample_bit;
  logic                 sample_tick;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_SIZE-1:0] shift_reg;
  logic                 shift_en;
  logic                 load_data;
  logic                 set_err;

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (rx_if.rx_in),
    .q_out  (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // rx_hist[0] is rx_s one cycle ago, rx_hist[1] two cycles ago.
  logic [1:0] rx_hist;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) rx_hist <= {2{IDLE_LEVEL}};
    else        rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample_bit = majority3(rx_s, rx_hist[0], rx_hist[1]);
`else
  assign sample_bit = rx_s;
`endif

  assign sample_tick    = (baud_cnt == DECIDE_AT);
  assign rx_if.busy_out = (state != IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load_data = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s == START_LEVEL) state_nxt = START;
      end
      START: begin
        if (sample_tick) state_nxt = (sample_bit == START_LEVEL) ? DATA : IDLE;
      end
      DATA: begin
        if (sample_tick) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (sample_bit == IDLE_LEVEL) begin
            load_data = 1'b1;
            state_nxt = IDLE;
          end else begin
            set_err   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      // A line stuck low must go high before another frame can start.
      BREAK: begin
        if (rx_s == IDLE_LEVEL) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter free-runs modulo CLK_BAUD_RATIO during a frame so that every
  // bit hits the same sample count; it is held at 0 while waiting for a start.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      baud_cnt <= '0;
    end else if (state == IDLE || state == BREAK || baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      if (state != DATA) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg <= {sample_bit, shift_reg[DATA_SIZE-1:1]};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_if.data_out      <= '0;
      rx_if.valid_out     <= 1'b0;
      rx_if.frame_err_out <= 1'b0;
    end else begin
      rx_if.valid_out     <= load_data;
      rx_if.frame_err_out <= set_err;
      if (load_data) rx_if.data_out <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx.
// A bit-level line driver pushes the expected outcome of each frame (word or
// framing error) into a queue; a negedge monitor pops it on every strobe.
// Honours UART_RX_MAJORITY_EN for the glitched-bit expectation.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int R    = 25;
  localparam int DS   = 8;
  localparam int HALF = R / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst_in;
  exp_t       exp_q[$];
  logic [7:0] last_good;
  int         checks = 0;
  int         errors = 0;

  uart_rx_if #(.DATA_SIZE(DS)) bus ();

  uart_rx #(.CLK_BAUD_RATIO(R), .DATA_SIZE(DS)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rx_if  (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance n clocks, then step just past the edge so line changes never race it.
  task automatic holdCycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Send one frame; glitch_k >= 0 flips the line for one cycle at the middle of bit k.
  task automatic applyStimulus(input logic [7:0] value, input bit stop_ok,
                               input int glitch_k, input int gap);
    exp_t       e;
    logic [9:0] frame;
    e.is_err = !stop_ok;
    e.data   = value;
    if (glitch_k >= 1 && glitch_k <= 8 && !MAJ) e.data = value ^ (8'd1 << (glitch_k - 1));
    exp_q.push_back(e);
    frame = {stop_ok ? IDLE_LEVEL : START_LEVEL, value, START_LEVEL};
    for (int k = 0; k < 10; k++) begin
      bus.rx_in = frame[k];
      if (k == glitch_k) begin
        holdCycles(HALF);
        bus.rx_in = ~frame[k];
        holdCycles(1);
        bus.rx_in = frame[k];
        holdCycles(R - HALF - 1);
      end else begin
        holdCycles(R);
      end
    end
    bus.rx_in = IDLE_LEVEL;
    if (gap > 0) holdCycles(gap);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && (bus.valid_out || bus.frame_err_out)) begin
      exp_t e;
      checkOutput("strobes_exclusive", {31'd0, bus.valid_out & bus.frame_err_out}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe actual valid=%0b err=%0b expected none at %0t",
                 bus.valid_out, bus.frame_err_out, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("strobe_kind_err", {31'd0, bus.frame_err_out}, {31'd0, e.is_err});
        if (e.is_err) begin
          checkOutput("data_hold_on_err", {24'd0, bus.data_out}, {24'd0, last_good});
        end else begin
          checkOutput("rx_data", {24'd0, bus.data_out}, {24'd0, e.data});
          last_good = e.data;
        end
      end
    end
  end

  initial begin
    int n;
    last_good  = 8'h00;
    rst_in     = 1'b1;
    bus.rx_in  = IDLE_LEVEL;
    #1;
    checkOutput("reset_data", {24'd0, bus.data_out}, 32'd0);
    checkOutput("reset_valid", {31'd0, bus.valid_out}, 32'd0);
    checkOutput("reset_err", {31'd0, bus.frame_err_out}, 32'd0);
    checkOutput("reset_busy", {31'd0, bus.busy_out}, 32'd0);
    holdCycles(3);
    rst_in = 1'b0;
    holdCycles(5);

    // Single good frame.
    applyStimulus(8'hA5, 1'b1, -1, 2 * R);

    // Short low pulse must be rejected as a false start.
    bus.rx_in = START_LEVEL;
    holdCycles(5);
    bus.rx_in = IDLE_LEVEL;
    checkOutput("pulse_busy_set", {31'd0, bus.busy_out}, 32'd1);
    n = 0;
    while (bus.busy_out && n < 15) begin
      holdCycles(1);
      n++;
    end
    checkOutput("pulse_busy_clear", {31'd0, bus.busy_out}, 32'd0);
    holdCycles(R);

    // Framing error, then a line held low, then recovery.
    applyStimulus(8'h3C, 1'b0, -1, 0);
    bus.rx_in = START_LEVEL;
    holdCycles(100);
    checkOutput("break_busy", {31'd0, bus.busy_out}, 32'd1);
    bus.rx_in = IDLE_LEVEL;
    holdCycles(2 * R);
    checkOutput("break_released", {31'd0, bus.busy_out}, 32'd0);
    applyStimulus(8'h11, 1'b1, -1, 2 * R);

    // Back-to-back frames with no idle time between them.
    applyStimulus(8'h00, 1'b1, -1, 0);
    applyStimulus(8'hFF, 1'b1, -1, 0);
    applyStimulus(8'h5A, 1'b1, -1, 2 * R);

    // Reset in the middle of data bit 3 (frame bit 4).
    bus.rx_in = START_LEVEL;
    holdCycles(R);
    bus.rx_in = 1'b1;
    holdCycles(3 * R + HALF);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("midreset_data", {24'd0, bus.data_out}, 32'd0);
    checkOutput("midreset_valid", {31'd0, bus.valid_out}, 32'd0);
    checkOutput("midreset_err", {31'd0, bus.frame_err_out}, 32'd0);
    checkOutput("midreset_busy", {31'd0, bus.busy_out}, 32'd0);
    bus.rx_in = IDLE_LEVEL;
    last_good = 8'h00;
    holdCycles(2);
    rst_in = 1'b0;
    holdCycles(2 * R);
    applyStimulus(8'hC3, 1'b1, -1, 2 * R);

    // One-cycle glitch on data bit 3 of 0x00.
    applyStimulus(8'h00, 1'b1, 4, 2 * R);

    // Random words, gaps and occasional bad stop bits.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] v;
      bit         ok;
      int         gap;
      v   = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      gap = ok ? int'($urandom_range(0, R)) : R + int'($urandom_range(0, R));
      applyStimulus(v, ok, -1, gap);
    end

    holdCycles(3 * R);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
